// File: rtl/pong_game_sequencer.sv
// PonG game-state controller: one frame step per accepted tick, moving paddles and ball,
// resolving wall/paddle bounces, keeping score and sequencing serve, play and game over.
module pong_game_sequencer #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int BALL_SZ      = 8,
    parameter int P1_X         = 16,
    parameter int P2_X         = 616,
    parameter int BALL_SPEED   = 4,
    parameter int PADDLE_SPEED = 4,
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       frame_tick,
    input  logic       busy,
    input  logic       start,
    input  logic [1:0] p1_ctrl,
    input  logic [1:0] p2_ctrl,
    input  logic [1:0] random,
    output logic [9:0] bx,
    output logic [9:0] by,
    output logic [9:0] p1x,
    output logic [9:0] p1y,
    output logic [9:0] p2x,
    output logic [9:0] p2y,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       game_over,
    output logic       winner,
    output logic       upd_done,
    output logic       frame_drop,
    output logic [2:0] dbg_state
);
    // Handshake: frame_tick raises pending; a step is accepted in any SERVE/PLAY cycle with
    // pending & !busy, runs for one STEP cycle and commits at that cycle's closing edge.
    typedef enum logic [2:0] {
        S_IDLE, S_SERVE, S_PLAY, S_STEP_SERVE, S_STEP_PLAY, S_OVER
    } state_t;

    localparam logic signed [10:0] SPD     = 11'(BALL_SPEED);
    localparam logic signed [10:0] X_MAX   = 11'(SCREEN_W - BALL_SZ);
    localparam logic signed [10:0] Y_MAX   = 11'(SCREEN_H - BALL_SZ);
    localparam logic signed [10:0] P1_FACE = 11'(P1_X + PADDLE_W);
    localparam logic signed [10:0] P2_FACE = 11'(P2_X - BALL_SZ);
    localparam logic signed [10:0] BALL    = 11'(BALL_SZ);
    localparam logic signed [10:0] PH      = 11'(PADDLE_H);
    localparam logic [9:0]  BX0    = 10'((SCREEN_W - BALL_SZ) / 2);
    localparam logic [9:0]  BY0    = 10'((SCREEN_H - BALL_SZ) / 2);
    localparam logic [9:0]  PY0    = 10'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [9:0]  PY_MAX = 10'(SCREEN_H - PADDLE_H);
    localparam logic [9:0]  PSPD   = 10'(PADDLE_SPEED);
    localparam logic [3:0]  WIN4   = 4'(WIN_SCORE);
    localparam logic [15:0] RELOAD = 16'(SERVE_FRAMES);

    state_t      state_q;
    logic [9:0]  bx_q, by_q, p1y_q, p2y_q;
    logic        dx_q, dy_q;
    logic [3:0]  score1_q, score2_q;
    logic [15:0] cnt_q;
    logic        pending_q, game_over_q, winner_q, upd_done_q, frame_drop_q;

    logic [9:0]  bx_d, by_d, p1y_d, p2y_d;
    logic        dx_d, dy_d, point1, point2;
    logic [3:0]  s1_inc, s2_inc;
    logic signed [10:0] bx_s, by_s, p1y_s, p2y_s, nx, ny;

    function automatic logic [9:0] paddle_next(input logic [9:0] y, input logic [1:0] ctrl);
        logic [9:0] r;
        r = y;
        if (ctrl == 2'b10)      r = (y < PSPD) ? 10'd0 : y - PSPD;
        else if (ctrl == 2'b01) r = (y > PY_MAX - PSPD) ? PY_MAX : y + PSPD;
        return r;
    endfunction

    // Ball collisions are judged against the paddle positions from before this step.
    always_comb begin
        p1y_d  = paddle_next(p1y_q, p1_ctrl);
        p2y_d  = paddle_next(p2y_q, p2_ctrl);
        bx_s   = signed'({1'b0, bx_q});
        by_s   = signed'({1'b0, by_q});
        p1y_s  = signed'({1'b0, p1y_q});
        p2y_s  = signed'({1'b0, p2y_q});
        nx     = dx_q ? bx_s + SPD : bx_s - SPD;
        ny     = dy_q ? by_s + SPD : by_s - SPD;
        s1_inc = score1_q + 4'd1;
        s2_inc = score2_q + 4'd1;
        by_d   = ny[9:0];
        dy_d   = dy_q;
        if (ny < 11'sd0) begin
            by_d = 10'd0;
            dy_d = 1'b1;
        end else if (ny > Y_MAX) begin
            by_d = Y_MAX[9:0];
            dy_d = 1'b0;
        end
        bx_d   = nx[9:0];
        dx_d   = dx_q;
        point1 = 1'b0;
        point2 = 1'b0;
        if (!dx_q && bx_s >= P1_FACE && nx < P1_FACE && by_s + BALL > p1y_s && by_s < p1y_s + PH) begin
            bx_d = P1_FACE[9:0];
            dx_d = 1'b1;
        end else if (dx_q && bx_s <= P2_FACE && nx > P2_FACE && by_s + BALL > p2y_s && by_s < p2y_s + PH) begin
            bx_d = P2_FACE[9:0];
            dx_d = 1'b0;
        end else if (nx < 11'sd0) begin
            point2 = 1'b1;
        end else if (nx > X_MAX) begin
            point1 = 1'b1;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q      <= S_IDLE;
            bx_q         <= BX0;
            by_q         <= BY0;
            p1y_q        <= PY0;
            p2y_q        <= PY0;
            dx_q         <= 1'b1;
            dy_q         <= 1'b1;
            score1_q     <= 4'd0;
            score2_q     <= 4'd0;
            cnt_q        <= 16'd0;
            pending_q    <= 1'b0;
            game_over_q  <= 1'b0;
            winner_q     <= 1'b0;
            upd_done_q   <= 1'b0;
            frame_drop_q <= 1'b0;
        end else begin
            upd_done_q   <= 1'b0;
            frame_drop_q <= 1'b0;
            case (state_q)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        state_q     <= S_SERVE;
                        bx_q        <= BX0;
                        by_q        <= BY0;
                        p1y_q       <= PY0;
                        p2y_q       <= PY0;
                        dx_q        <= random[0];
                        dy_q        <= random[1];
                        score1_q    <= 4'd0;
                        score2_q    <= 4'd0;
                        cnt_q       <= RELOAD;
                        pending_q   <= 1'b0;
                        game_over_q <= 1'b0;
                        winner_q    <= 1'b0;
                    end
                end
                S_SERVE, S_PLAY: begin
                    if (frame_tick && pending_q) frame_drop_q <= 1'b1;
                    if (pending_q && !busy) begin
                        pending_q <= 1'b0;
                        state_q   <= (state_q == S_SERVE) ? S_STEP_SERVE : S_STEP_PLAY;
                    end else if (frame_tick) begin
                        pending_q <= 1'b1;
                    end
                end
                S_STEP_SERVE: begin
                    upd_done_q   <= 1'b1;
                    frame_drop_q <= frame_tick;
                    p1y_q        <= p1y_d;
                    p2y_q        <= p2y_d;
                    if (cnt_q <= 16'd1) begin
                        cnt_q   <= 16'd0;
                        state_q <= S_PLAY;
                    end else begin
                        cnt_q   <= cnt_q - 16'd1;
                        state_q <= S_SERVE;
                    end
                end
                S_STEP_PLAY: begin
                    upd_done_q   <= 1'b1;
                    frame_drop_q <= frame_tick;
                    p1y_q        <= p1y_d;
                    p2y_q        <= p2y_d;
                    bx_q         <= bx_d;
                    by_q         <= by_d;
                    dx_q         <= dx_d;
                    dy_q         <= dy_d;
                    state_q      <= S_PLAY;
                    if (point1 || point2) begin
                        // Re-serve toward the player who just conceded.
                        bx_q  <= BX0;
                        by_q  <= BY0;
                        cnt_q <= RELOAD;
                        dx_q  <= point1;
                        dy_q  <= random[1];
                        if (point1) begin
                            score1_q <= s1_inc;
                            if (s1_inc == WIN4) begin
                                state_q     <= S_OVER;
                                game_over_q <= 1'b1;
                                winner_q    <= 1'b0;
                            end else begin
                                state_q <= S_SERVE;
                            end
                        end else begin
                            score2_q <= s2_inc;
                            if (s2_inc == WIN4) begin
                                state_q     <= S_OVER;
                                game_over_q <= 1'b1;
                                winner_q    <= 1'b1;
                            end else begin
                                state_q <= S_SERVE;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bx         = bx_q;
    assign by         = by_q;
    assign p1x        = 10'(P1_X);
    assign p1y        = p1y_q;
    assign p2x        = 10'(P2_X);
    assign p2y        = p2y_q;
    assign score1     = score1_q;
    assign score2     = score2_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;
    assign upd_done   = upd_done_q;
    assign frame_drop = frame_drop_q;
    assign dbg_state  = state_q;

endmodule
